cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 86 ++++++++
 tb/tb_cache_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one downstream memory port between the instruction and data caches,
// one outstanding transaction at a time, alternating grants when both sides contend.
module cache_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_cache_req,
  input  logic [31:0] inst_cache_addr,
  output logic [31:0] inst_cache_rdata,
  output logic        inst_cache_dok,
  input  logic        data_cache_req,
  input  logic [3:0]  data_cache_wen,
  input  logic [31:0] data_cache_addr,
  input  logic [31:0] data_cache_wdata,
  output logic [31:0] data_cache_rdata,
  output logic        data_cache_dok,
  output logic        mem_req,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic [31:0] mem_rdata,
  input  logic        mem_data_ok
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d, last_q, last_d, grant_data;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  // owner/last: 1 = data side
  assign grant_data = data_cache_req & (~inst_cache_req | ~last_q);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (inst_cache_req | data_cache_req) begin
        state_d = REQ;
        owner_d = grant_data;
        last_d  = grant_data;
        wen_d   = grant_data ? data_cache_wen : 4'b0;
        addr_d  = grant_data ? data_cache_addr : inst_cache_addr;
        wdata_d = grant_data ? data_cache_wdata : 32'b0;
      end
      REQ: if (mem_addr_ok) begin
        state_d = mem_data_ok ? RESP : WAIT;
        rdata_d = mem_data_ok ? mem_rdata : rdata_q;
      end
      WAIT: if (mem_data_ok) begin
        state_d = RESP;
        rdata_d = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      wen_q   <= 4'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign mem_req          = state_q == REQ;
  assign mem_wen          = wen_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign inst_cache_dok   = state_q == RESP && !owner_q;
  assign data_cache_dok   = state_q == RESP && owner_q;
  assign inst_cache_rdata = rdata_q;
  assign data_cache_rdata = rdata_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed requesters and a downstream memory model feeding scoreboards
// that are popped by monitors on every mem_req cycle and every dok pulse.
module tb_cache_arbiter;
  logic        clk, reset;
  logic        inst_cache_req, inst_cache_dok, data_cache_req, data_cache_dok;
  logic [31:0] inst_cache_addr, inst_cache_rdata, data_cache_addr, data_cache_wdata, data_cache_rdata;
  logic [3:0]  data_cache_wen, mem_wen;
  logic        mem_req, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  cache_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_cache_req(inst_cache_req), .inst_cache_addr(inst_cache_addr),
    .inst_cache_rdata(inst_cache_rdata), .inst_cache_dok(inst_cache_dok),
    .data_cache_req(data_cache_req), .data_cache_wen(data_cache_wen),
    .data_cache_addr(data_cache_addr), .data_cache_wdata(data_cache_wdata),
    .data_cache_rdata(data_cache_rdata), .data_cache_dok(data_cache_dok),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_rdata(mem_rdata), .mem_data_ok(mem_data_ok)
  );

  typedef struct {logic [3:0] wen; logic [31:0] addr; logic [31:0] wdata;} mreq_t;
  typedef struct {bit own; logic [31:0] rd;} resp_t;

  mreq_t       exp_m[$], d_pend[$];
  resp_t       exp_r[$];
  logic [31:0] i_pend[$];
  int checks = 0, errors = 0, cyc = 0;
  int stall = 0, lat = 0, acnt = 0, dcnt = 0, mreq_cycles = 0;
  int i_start = 0, d_start = 0, lat_i = 0, lat_d = 0, prev_dok = 0, last_gap = 0;
  bit i_on = 0, d_on = 0, spur = 0;
  logic [31:0] paddr = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a == 32'h1FC00000 ? 32'h24080001 : a ^ 32'hA5A5A5A5;
  endfunction

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  task automatic expect_txn(input bit own, input logic [3:0] wen, input logic [31:0] a,
                            input logic [31:0] w, input logic [31:0] rd);
    mreq_t m;
    resp_t r;
    m.wen = wen; m.addr = a; m.wdata = w;
    r.own = own; r.rd = rd;
    exp_m.push_back(m);
    exp_r.push_back(r);
  endtask

  task automatic push_inst(input logic [31:0] a, input logic [31:0] rd);
    i_pend.push_back(a);
    expect_txn(1'b0, 4'b0, a, 32'b0, rd);
  endtask

  task automatic push_data(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] w);
    mreq_t m;
    m.wen = wen; m.addr = a; m.wdata = w;
    d_pend.push_back(m);
    expect_txn(1'b1, wen, a, w, rd_of(a));
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string n);
    for (int k = 0; k < 80; k++) begin
      sync();
      if (exp_r.size() == 0 && exp_m.size() == 0 && i_pend.size() == 0 && d_pend.size() == 0
          && !inst_cache_req && !data_cache_req) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout with %0d responses outstanding, expected 0", n, exp_r.size());
    exp_r.delete(); exp_m.delete(); i_pend.delete(); d_pend.delete();
  endtask

  // instruction requester: holds req and address until its dok
  always @(negedge clk) begin
    if (reset) begin
      inst_cache_req = 0;
      i_on = 0;
    end else begin
      if (inst_cache_dok && i_on) begin
        i_pend.delete(0);
        i_on = 0;
        lat_i = cyc - i_start;
      end
      if (i_pend.size() > 0 && !i_on) begin
        i_on = 1;
        i_start = cyc;
        inst_cache_addr = i_pend[0];
      end
      inst_cache_req = i_on;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      data_cache_req = 0;
      d_on = 0;
    end else begin
      if (data_cache_dok && d_on) begin
        d_pend.delete(0);
        d_on = 0;
        lat_d = cyc - d_start;
      end
      if (d_pend.size() > 0 && !d_on) begin
        d_on = 1;
        d_start = cyc;
        data_cache_wen = d_pend[0].wen;
        data_cache_addr = d_pend[0].addr;
        data_cache_wdata = d_pend[0].wdata;
      end
      data_cache_req = d_on;
    end
  end

  // downstream memory model: stalls addr_ok by 'stall' cycles, returns data 'lat' cycles later
  always @(negedge clk) begin
    mem_addr_ok = 0;
    mem_data_ok = 0;
    if (reset) begin
      acnt = 0;
      dcnt = 0;
    end else if (mem_req) begin
      mreq_cycles++;
      if (exp_m.size() == 0) chk("unexpected_mem_req", {31'b0, mem_req}, 32'b0);
      else begin
        chk("mem_wen", {28'b0, mem_wen}, {28'b0, exp_m[0].wen});
        chk("mem_addr", mem_addr, exp_m[0].addr);
        chk("mem_wdata", mem_wdata, exp_m[0].wdata);
      end
      if (acnt < stall) acnt++;
      else begin
        acnt = 0;
        mem_addr_ok = 1;
        paddr = mem_addr;
        if (exp_m.size() > 0) exp_m.delete(0);
        if (lat == 0) begin
          mem_data_ok = 1;
          mem_rdata = rd_of(mem_addr);
        end else dcnt = lat;
      end
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        mem_data_ok = 1;
        mem_rdata = rd_of(paddr);
      end
    end else if (spur) begin
      spur = 0;
      mem_data_ok = 1;
      mem_rdata = 32'hBAD0BAD0;
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (!reset && (inst_cache_dok || data_cache_dok)) begin
      last_gap = cyc - prev_dok;
      prev_dok = cyc;
      if (inst_cache_dok && data_cache_dok) chk("both_dok", 32'd1, 32'd0);
      if (exp_r.size() == 0) chk("unexpected_dok", {30'b0, data_cache_dok, inst_cache_dok}, 32'b0);
      else begin
        chk("dok_owner", {31'b0, data_cache_dok}, {31'b0, exp_r[0].own});
        chk("dok_rdata", data_cache_dok ? data_cache_rdata : inst_cache_rdata, exp_r[0].rd);
        exp_r.delete(0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    inst_cache_req = 0; inst_cache_addr = 0;
    data_cache_req = 0; data_cache_wen = 0; data_cache_addr = 0; data_cache_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    repeat (3) sync();
    chk("rst_mem_req", {31'b0, mem_req}, 32'b0);
    chk("rst_dok", {30'b0, inst_cache_dok, data_cache_dok}, 32'b0);
    chk("rst_mem_wen", {28'b0, mem_wen}, 32'b0);
    chk("rst_mem_addr", mem_addr, 32'b0);
    chk("rst_mem_wdata", mem_wdata, 32'b0);
    chk("rst_rdata", inst_cache_rdata, 32'b0);
    reset = 0;
    sync();
    // inst-only read with a two-cycle gap between addr_ok and data_ok
    lat = 2;
    push_inst(32'h1FC00000, 32'h24080001);
    wait_idle("inst_read");
    chk("inst_read_latency", lat_i, 4);
    // simultaneous requests: data first
    lat = 0;
    push_data(4'b0, 32'h80000010, 32'b0);
    push_inst(32'h1FC00004, 32'h1FC00004 ^ 32'hA5A5A5A5);
    expect_txn(1'b0, 4'b0, 32'h0, 32'h0, 32'h0);
    exp_r.delete(exp_r.size() - 1);
    exp_m.delete(exp_m.size() - 1);
    wait_idle("contended");
    // minimum latency with coincident addr_ok/data_ok
    push_inst(32'h1FC00008, 32'h1FC00008 ^ 32'hA5A5A5A5);
    wait_idle("min_latency");
    chk("min_latency", lat_i, 2);
    // continuous contention: D I D I D I
    for (int k = 0; k < 3; k++) begin
      mreq_t m;
      resp_t r;
      m.wen = 4'b0; m.addr = 32'h80000100 + 4 * k; m.wdata = 32'b0;
      d_pend.push_back(m);
      i_pend.push_back(32'h1FC00010 + 4 * k);
      expect_txn(1'b1, 4'b0, m.addr, 32'b0, rd_of(m.addr));
      expect_txn(1'b0, 4'b0, 32'h1FC00010 + 4 * k, 32'b0, rd_of(32'h1FC00010 + 4 * k));
    end
    wait_idle("alternate");
    chk("back_to_back_gap", last_gap, 3);
    // data write with addr_ok stalled 3 cycles
    stall = 3;
    lat = 1;
    mreq_cycles = 0;
    push_data(4'b0011, 32'h80000020, 32'hDEADBEEF);
    wait_idle("write_stall");
    chk("write_mem_req_cycles", mreq_cycles, 4);
    chk("write_latency", lat_d, 6);
    stall = 0;
    // reset while in WAIT, then a stray data_ok
    lat = 6;
    d_pend.push_back('{4'b0, 32'h80000040, 32'b0});
    exp_m.push_back('{4'b0, 32'h80000040, 32'b0});
    for (int k = 0; k < 20 && !mem_req; k++) sync();
    for (int k = 0; k < 20 && mem_req; k++) sync();
    reset = 1;
    d_pend.delete();
    dcnt = 0;
    sync();
    chk("midrst_mem_req", {31'b0, mem_req}, 32'b0);
    chk("midrst_rdata", data_cache_rdata, 32'b0);
    reset = 0;
    spur = 1;
    for (int k = 0; k < 4; k++) begin
      sync();
      chk("midrst_no_dok", {30'b0, inst_cache_dok, data_cache_dok}, 32'b0);
      chk("midrst_idle", {31'b0, mem_req}, 32'b0);
    end
    chk("spurious_ignored", inst_cache_rdata, 32'b0);
    // last-grant is back to inst after reset, so data wins the next contention
    lat = 0;
    push_data(4'b0, 32'h80000030, 32'b0);
    push_inst(32'h1FC00100, 32'h1FC00100 ^ 32'hA5A5A5A5);
    wait_idle("post_reset_contended");
    push_inst(32'h1FC00104, 32'h1FC00104 ^ 32'hA5A5A5A5);
    wait_idle("post_reset_inst");
    chk("post_reset_latency", lat_i, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
